// File: rtl/board_pkg.sv
// board_pkg: shared types and constants for the board reset sequencer.
//   rst_seq_state_e : sequencer states
//   SYNC_STAGES     : depth of every input synchroniser
package board_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      RESET,
      WAIT_READY,
      HOLD,
      RELEASE,
      RUN
   } rst_seq_state_e;

endpackage

// File: rtl/board_rst_seq_if.sv
// board_rst_seq_if: board-side status inputs and reset outputs of the sequencer.
//   btn_rstn   : asynchronous board reset button, active-low
//   ready_i    : asynchronous readiness flags (MMCM locked, DDR cal done, ...)
//   stage_rst  : per-domain resets, active-high, bit 0 released first
//   all_up     : every stage released
//   lost_ready : sticky, a ready input dropped after release
//   retry_rst  : watchdog retry pulse to upstream clock/memory IP
// master = sequencer side, slave = board/consumer side.
interface board_rst_seq_if #(
   parameter int unsigned NUM_READY  = 2,
   parameter int unsigned NUM_STAGES = 2
);

   logic                  btn_rstn;
   logic [NUM_READY-1:0]  ready_i;
   logic [NUM_STAGES-1:0] stage_rst;
   logic                  all_up;
   logic                  lost_ready;
   logic                  retry_rst;

   modport master (
      input  btn_rstn, ready_i,
      output stage_rst, all_up, lost_ready, retry_rst
   );

   modport slave (
      output btn_rstn, ready_i,
      input  stage_rst, all_up, lost_ready, retry_rst
   );

endinterface

// File: rtl/board_sync_debounce.sv
// board_sync_debounce: SYNC_STAGES-flop synchroniser with optional debounce.
//   clk, rst  : board clock, synchronous active-high reset
//   async_in  : asynchronous input
//   sync_out  : synchronised value; with DEBOUNCE > 0 it only changes after the
//               synchronised input has differed from it for DEBOUNCE cycles
// DEBOUNCE = 0 gives a plain synchroniser. All flops reset to 0.
module board_sync_debounce
   import board_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      end
   end

   assign sync_val = sync_q[SYNC_STAGES-1];

   if (DEBOUNCE == 0) begin : g_plain
      assign sync_out = sync_val;
   end else begin : g_debounce
      localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

      logic [CW-1:0] cnt_q;
      logic          deb_q;

      // cnt_q counts consecutive samples that disagree with deb_q; any
      // agreeing sample restarts the count.
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
         end else if (sync_val == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
            cnt_q <= '0;
            deb_q <= sync_val;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end

      assign sync_out = deb_q;
   end

endmodule

// File: rtl/board_rst_seq.sv
// board_rst_seq: board reset sequencer.
// Synchronises NUM_READY readiness flags, debounces the board reset button and
// releases NUM_STAGES reset domains in order: stage 0 after HOLD_CYCLES+1
// all-ready cycles, then one more stage every STAGE_GAP cycles.
//   clk  : board clock
//   rst  : synchronous active-high reset
//   bus  : board_rst_seq_if.master (btn_rstn, ready_i in; stage_rst, all_up,
//          lost_ready, retry_rst out)
// Optional feature macro: BOARD_RST_SEQ_WATCHDOG_EN enables the watchdog that
// pulses retry_rst for RETRY_CYCLES after TIMEOUT_CYCLES cycles spent waiting;
// otherwise retry_rst is tied to 0.
module board_rst_seq
   import board_pkg::*;
#(
   parameter int unsigned NUM_READY       = 2,
   parameter int unsigned NUM_STAGES      = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES     = 16,
   parameter int unsigned STAGE_GAP       = 8
`ifdef BOARD_RST_SEQ_WATCHDOG_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES  = 1 << 20,
   parameter int unsigned RETRY_CYCLES    = 64
`endif
) (
   input  logic             clk,
   input  logic             rst,
   board_rst_seq_if.master  bus
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int unsigned IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
   localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

   logic [NUM_READY-1:0] ready_sync;
   logic                 btn_deb;
   logic                 all_ready;
   logic                 press;
   logic                 press_onset;

   rst_seq_state_e       state_q, state_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                 all_up_q, all_up_d;
   logic                 lost_q, lost_d;
   logic                 press_q;

   for (genvar i = 0; i < NUM_READY; i++) begin : g_ready
      board_sync_debounce #(.DEBOUNCE(0)) u_sync (
         .clk      (clk),
         .rst      (rst),
         .async_in (bus.ready_i[i]),
         .sync_out (ready_sync[i])
      );
   end

   board_sync_debounce #(.DEBOUNCE(DEBOUNCE_CYCLES)) u_btn (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus.btn_rstn),
      .sync_out (btn_deb)
   );

   assign all_ready   = &ready_sync;
   assign press       = ~btn_deb;
   // lost_ready is cleared by the start of a press, not by holding the button,
   // so a ready drop coinciding with a held press stays visible.
   assign press_onset = press & ~press_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RESET;
         hold_q   <= '0;
         gap_q    <= '0;
         idx_q    <= '0;
         stage_q  <= '1;
         all_up_q <= 1'b0;
         lost_q   <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         gap_q    <= gap_d;
         idx_q    <= idx_d;
         stage_q  <= stage_d;
         all_up_q <= all_up_d;
         lost_q   <= lost_d;
         press_q  <= press;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      gap_d    = gap_q;
      idx_d    = idx_q;
      stage_d  = stage_q;
      all_up_d = all_up_q;
      lost_d   = lost_q;

      if (press_onset) begin
         lost_d = 1'b0;
      end

      case (state_q)
         RESET: begin
            stage_d  = '1;
            all_up_d = 1'b0;
            state_d  = WAIT_READY;
         end

         WAIT_READY: begin
            stage_d  = '1;
            all_up_d = 1'b0;
            if (all_ready && !press) begin
               state_d = HOLD;
               hold_d  = '0;
            end
         end

         HOLD: begin
            if (!all_ready || press) begin
               state_d = WAIT_READY;
            end else if (hold_q == HW'(HOLD_CYCLES)) begin
               stage_d[0] = 1'b0;
               gap_d      = '0;
               idx_d      = '0;
               if (NUM_STAGES == 1) begin
                  all_up_d = 1'b1;
                  state_d  = RUN;
               end else begin
                  state_d  = RELEASE;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         RELEASE, RUN: begin
            if (!all_ready || press) begin
               stage_d  = '1;
               all_up_d = 1'b0;
               state_d  = WAIT_READY;
               if (!all_ready) begin
                  lost_d = 1'b1;
               end
            end else if (state_q == RELEASE) begin
               if (gap_q == GW'(STAGE_GAP - 1)) begin
                  gap_d   = '0;
                  idx_d   = idx_q + 1'b1;
                  stage_d = stage_q & ~(STAGE_ONE << (idx_q + 1'b1));
                  if (idx_q == IW'(NUM_STAGES - 2)) begin
                     all_up_d = 1'b1;
                     state_d  = RUN;
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = RESET;
         end
      endcase
   end

   assign bus.stage_rst  = stage_q;
   assign bus.all_up     = all_up_q;
   assign bus.lost_ready = lost_q;

`ifdef BOARD_RST_SEQ_WATCHDOG_EN
   localparam int unsigned RW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

   logic [31:0]   wd_cnt_q;
   logic [RW-1:0] retry_cnt_q;
   logic          retry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q    <= '0;
         retry_cnt_q <= '0;
         retry_q     <= 1'b0;
      end else begin
         if (retry_q) begin
            if (retry_cnt_q == '0) begin
               retry_q <= 1'b0;
            end else begin
               retry_cnt_q <= retry_cnt_q - 1'b1;
            end
         end
         if (state_q == WAIT_READY || state_q == HOLD) begin
            if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               wd_cnt_q <= '0;
               if (!retry_q) begin
                  retry_q     <= 1'b1;
                  retry_cnt_q <= RW'(RETRY_CYCLES - 1);
               end
            end else begin
               wd_cnt_q <= wd_cnt_q + 1'b1;
            end
         end else begin
            wd_cnt_q <= '0;
         end
      end
   end

   assign bus.retry_rst = retry_q;
`else
   assign bus.retry_rst = 1'b0;
`endif

endmodule

// File: doc/board_rst_seq.md
# board_rst_seq

Parametrised board reset sequencer that replaces the single-term "locked AND calibrated" system reset of the board abstraction layers. It synchronises N asynchronous readiness inputs (e.g. MMCM locked, DDR calibration done), debounces the active-low board reset button, and releases M downstream reset domains in a fixed order with programmable hold and gap times. It sits inside each board top, between clock/memory-controller status and the system/NoC/CPU reset inputs.

## Interface
- NUM_READY, 2, number of readiness inputs; all must be high to leave reset
- NUM_STAGES, 2, number of ordered reset outputs
- DEBOUNCE_CYCLES, 16, cycles the synchronised button must be stable before its debounced value changes
- HOLD_CYCLES, 16, consecutive all-ready cycles required before the first release (≥1)
- STAGE_GAP, 8, cycles between successive stage releases (≥1)
- TIMEOUT_CYCLES, 1<<20, watchdog limit (only with the macro)
- RETRY_CYCLES, 64, width of the retry_rst pulse (only with the macro)

Ports:
- clk  in  1  board clock
- rst  in  1  reset, synchronous, active-high
- btn_rstn  in  1  asynchronous board reset button, active-low
- ready_i  in  NUM_READY  asynchronous readiness flags
- stage_rst  out  NUM_STAGES  per-domain resets, active-high, bit 0 released first
- all_up  out  1  high while every stage is released
- lost_ready  out  1  sticky: a ready input dropped after release
- retry_rst  out  1  watchdog retry pulse to upstream clock/memory IP

## Operation
- ready_i and btn_rstn each pass through a 2-flop synchroniser (ready_sync, btn_sync). The debounced press is btn_sync low, stable for DEBOUNCE_CYCLES cycles.
- States: RESET, WAIT_READY, HOLD, RELEASE, RUN.
- RESET: every stage_rst is 1. Always moves to WAIT_READY on the next edge.
- WAIT_READY: when all ready_sync bits are 1 and no press is active, move to HOLD with hold_cnt = 0.
- HOLD: hold_cnt increments each cycle. Any ready_sync bit low returns to WAIT_READY. When hold_cnt reaches HOLD_CYCLES, clear stage_rst[0] and enter RELEASE with idx = 0 and gap_cnt = 0.
- RELEASE: gap_cnt counts to STAGE_GAP, then clears stage_rst[idx+1]. Clearing the last stage sets all_up and enters RUN.
- RELEASE/RUN abort: a ready_sync drop or a debounced press sets every stage_rst and clears all_up on the next edge, and returns to WAIT_READY. A ready drop also sets lost_ready.
- A debounced press in WAIT_READY or HOLD holds the sequencer in WAIT_READY.
- lost_ready clears only on rst or on a debounced press.
- Simultaneous ready drop and press: all stages reset, and lost_ready is set.

## Timing
- Reset values: stage_rst all 1, all_up 0, lost_ready 0, retry_rst 0, state RESET, all counters 0, synchronisers 0 (ready treated as low).
- Let edge c be the first WAIT_READY edge with ready_sync all high. Then:
  - stage_rst[k] falls at edge c+1+HOLD_CYCLES+k·STAGE_GAP.
  - all_up rises on the same edge as the last stage release.
- Input-to-ready_sync latency is 2 cycles.
- Abort latency from ready_sync low to all stage_rst high is 1 cycle.
- Any stage_rst is held high for at least HOLD_CYCLES+1 cycles after each abort.
- rst asserted mid-sequence overrides everything on the next edge.

## Configuration
- BOARD_RST_SEQ_WATCHDOG_EN defined:
  - A 32-bit counter runs while in WAIT_READY or HOLD and clears on entering RELEASE.
  - When it reaches TIMEOUT_CYCLES, retry_rst goes high for exactly RETRY_CYCLES cycles and the counter restarts.
  - retry_rst never re-triggers during its own pulse.
- Not defined: retry_rst is constant 0 and no counter is synthesised.

## Structure
- board_pkg holds:
  - the state typedef (rst_seq_state_e: RESET, WAIT_READY, HOLD, RELEASE, RUN)
  - constant SYNC_STAGES = 2
- Sub-module board_sync_debounce: 2-flop synchroniser plus optional stability counter (DEBOUNCE parameter; 0 means plain synchroniser). It is instantiated per ready bit (DEBOUNCE 0) and for the button.

## Test plan
All scenarios use HOLD_CYCLES=4, STAGE_GAP=3, NUM_STAGES=2, NUM_READY=2, DEBOUNCE_CYCLES=4.
- Power-up: rst for 3 cycles, then both ready_i set at edge 10 (ready_sync high at 12) -> stage_rst[0] falls at 17, stage_rst[1] and all_up at 20.
- Ready glitch in HOLD: ready_i[1] low for one cycle at edge 14 -> hold restarts, stage_rst[0] falls no earlier than 5 cycles after ready_sync returns high.
- Ready loss in RUN: ready_i[0] low at edge 30 -> stage_rst=2'b11, all_up=0, lost_ready=1 at edge 33, followed by a full re-sequence.
- Button bounce: btn_rstn toggling every 2 cycles -> no effect; held low for 10 cycles -> all stages reset, lost_ready cleared, release after the button goes high.
- Simultaneous press and ready drop in RUN -> stage_rst=2'b11 and lost_ready=1.
- Watchdog (macro defined, TIMEOUT_CYCLES=50, RETRY_CYCLES=5): ready_i held low -> retry_rst high for exactly 5 cycles, starting after 50 cycles in WAIT_READY. Repeats every 50 cycles. Without the macro, retry_rst stays 0.
